// File: rtl/pc_unit_pkg.sv
// Shared types and defaults for the program-counter unit.
// Imported by the RAS, the interface users and the top level.
package pc_pkg;

  typedef enum logic {
    PC_RUN,
    PC_HALTED
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_RAS,
    SEL_HOLD
  } pc_sel_e;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned INC_DEF       = 4;
  localparam int unsigned RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between decode/branch logic and the PC unit.
// master = decode side, slave = PC unit.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            stall;
  logic            halt;
  logic            resume;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic            call;
  logic [XLEN-1:0] jump_target;
  logic            ret;
  logic [XLEN-1:0] pc_out;
  logic            halted;
  logic            ras_empty;
  logic            ras_overflow;
  logic            ras_underflow;

  modport master (
    output stall, halt, resume,
    output branch_taken, branch_target,
    output jump, call, jump_target, ret,
    input  pc_out, halted,
    input  ras_empty, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, halt, resume,
    input  branch_taken, branch_target,
    input  jump, call, jump_target, ret,
    output pc_out, halted,
    output ras_empty, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: a push when full overwrites the
// oldest entry; pop has priority over push.
module return_addr_stack import pc_pkg::*; #(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d, top_inc;
  logic [PW:0]     cnt_q, cnt_d;
  logic            wr_en;

  assign top_inc = top_q + 1'b1;
  assign top_o   = mem_q[top_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (pop_i) begin
      if (!empty_o) begin
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (push_i) begin
      top_d = top_inc;
      wr_en = 1'b1;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      if (wr_en) mem_q[top_inc] <= data_i;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC select, sticky halt
// state and a return-address stack for call/return.
module pc_unit import pc_pkg::*; #(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = INC_DEF,
  parameter int unsigned     RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q, pc_d, pc_inc;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            push, pop, udf_set;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;

  assign pc_inc = pc_q + XLEN'(INC);

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_inc),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    udf_set = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        if (bus.halt) begin
          state_d = PC_HALTED;
        end else if (bus.stall) begin
          sel = SEL_HOLD;
        end else if (bus.ret) begin
          // Empty RAS falls through to sequential fetch
          if (ras_empty) begin
            sel     = SEL_SEQ;
            udf_set = 1'b1;
          end else begin
            sel = SEL_RAS;
            pop = 1'b1;
          end
        end else if (bus.call) begin
          sel  = SEL_JUMP;
          push = 1'b1;
        end else if (bus.jump) begin
          sel = SEL_JUMP;
        end else if (bus.branch_taken) begin
          sel = SEL_BRANCH;
        end else begin
          sel = SEL_SEQ;
        end
      end
      PC_HALTED: begin
        if (bus.resume && !bus.halt) state_d = PC_RUN;
      end
      default: state_d = PC_RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_SEQ:    pc_d = pc_inc;
      SEL_BRANCH: pc_d = bus.branch_target;
      SEL_JUMP:   pc_d = bus.jump_target;
      SEL_RAS:    pc_d = ras_top;
      SEL_HOLD:   pc_d = pc_q;
      default:    pc_d = pc_q;
    endcase
  end

  assign ovf_d = ovf_q | (push & ras_full);
  assign udf_d = udf_q | udf_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VECTOR;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.halted        = (state_q == PC_HALTED);
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = udf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance at 0x100 and an
// 8-bit instance at 0xF4 for wrap and async reset.
module tb_pc_unit;

  logic clk;
  logic reset;
  logic rst8;
  int   checks;
  int   errors;

  pc_unit_if #(.XLEN(32)) b ();
  pc_unit_if #(.XLEN(8))  b8 ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(32'h100), .INC(4), .RAS_DEPTH(4)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  pc_unit #(
    .XLEN(8), .RESET_VECTOR(8'hF4), .INC(4), .RAS_DEPTH(4)
  ) u1 (
    .clk(clk), .reset(rst8), .bus(b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b.stall = 0; b.halt = 0; b.resume = 0;
    b.branch_taken = 0; b.branch_target = '0;
    b.jump = 0; b.call = 0; b.jump_target = '0; b.ret = 0;
    b8.stall = 0; b8.halt = 0; b8.resume = 0;
    b8.branch_taken = 0; b8.branch_target = '0;
    b8.jump = 0; b8.call = 0; b8.jump_target = '0; b8.ret = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    rst8  = 1'b1;
    #12;
    checks++;
    if (b.pc_out !== 32'h100) begin
      errors++;
      $display("FAIL rst_pc got %h want %h", b.pc_out, 32'h100);
    end
    checks++;
    if ({b.halted, b.ras_empty, b.ras_overflow, b.ras_underflow} !== 4'b0100) begin
      errors++;
      $display("FAIL rst_flags got %b want 0100",
        {b.halted, b.ras_empty, b.ras_overflow, b.ras_underflow});
    end
    checks++;
    if (b8.pc_out !== 8'hF4) begin
      errors++;
      $display("FAIL rst_pc8 got %h want f4", b8.pc_out);
    end
    @(negedge clk);
    reset = 1'b0;
    rst8  = 1'b0;
  endtask

  task automatic test_seq();
    logic [31:0] exp;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = 32'h100 + 32'(4 * i);
      checks++;
      if (b.pc_out !== exp) begin
        errors++;
        $display("FAIL seq%0d got %h want %h", i, b.pc_out, exp);
      end
    end
  endtask

  task automatic test_branch_jump();
    b.jump = 1; b.jump_target = 32'h10;
    step();
    checks++;
    if (b.pc_out !== 32'h10) begin
      errors++;
      $display("FAIL bj_setup got %h want 10", b.pc_out);
    end
    b.branch_taken = 1; b.branch_target = 32'h40;
    b.jump = 1; b.jump_target = 32'h80;
    step();
    checks++;
    if (b.pc_out !== 32'h80) begin
      errors++;
      $display("FAIL bj_prio got %h want 80", b.pc_out);
    end
    clear_inputs();
    step();
    checks++;
    if (b.pc_out !== 32'h84) begin
      errors++;
      $display("FAIL bj_next got %h want 84", b.pc_out);
    end
  endtask

  task automatic test_call_chain();
    logic [31:0] rexp [4];
    rexp[0] = 32'h44; rexp[1] = 32'h34;
    rexp[2] = 32'h24; rexp[3] = 32'h14;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b.jump = 1; b.jump_target = 32'(16 * i);
      step();
      b.jump = 0;
      if (i == 4) begin
        checks++;
        if (b.ras_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got %b want 0", b.ras_overflow);
        end
      end
      b.call = 1; b.jump_target = 32'h200;
      step();
      b.call = 0;
      checks++;
      if (b.pc_out !== 32'h200) begin
        errors++;
        $display("FAIL call%0d got %h want 200", i, b.pc_out);
      end
    end
    checks++;
    if ({b.ras_overflow, b.ras_empty} !== 2'b10) begin
      errors++;
      $display("FAIL ovf got %b want 10", {b.ras_overflow, b.ras_empty});
    end
    b.ret = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (b.pc_out !== rexp[k]) begin
        errors++;
        $display("FAIL ret%0d got %h want %h", k, b.pc_out, rexp[k]);
      end
    end
    checks++;
    if ({b.ras_empty, b.ras_underflow} !== 2'b10) begin
      errors++;
      $display("FAIL ret_empty got %b want 10", {b.ras_empty, b.ras_underflow});
    end
    step();
    b.ret = 0;
    checks++;
    if (b.pc_out !== 32'h18 || b.ras_underflow !== 1'b1) begin
      errors++;
      $display("FAIL udf got pc %h f %b want 18 1", b.pc_out, b.ras_underflow);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    b.jump = 1; b.jump_target = 32'h50;
    step();
    b.jump = 0; b.call = 1; b.jump_target = 32'h200;
    step();
    b.ret = 1; b.jump_target = 32'h300;
    step();
    clear_inputs();
    checks++;
    if (b.pc_out !== 32'h54 || b.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL callret got pc %h e %b want 54 1", b.pc_out, b.ras_empty);
    end
  endtask

  task automatic test_halt();
    b.jump = 1; b.jump_target = 32'h20;
    step();
    b.halt = 1; b.jump_target = 32'h99;
    step();
    b.halt = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b.pc_out !== 32'h20 || b.halted !== 1'b1) begin
        errors++;
        $display("FAIL halt%0d got pc %h h %b want 20 1", i, b.pc_out, b.halted);
      end
      if (i < 4) step();
    end
    b.halt = 1; b.resume = 1;
    step();
    checks++;
    if (b.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_dom got %b want 1", b.halted);
    end
    b.halt = 0; b.jump = 0;
    step();
    checks++;
    if (b.pc_out !== 32'h20 || b.halted !== 1'b0) begin
      errors++;
      $display("FAIL resume got pc %h h %b want 20 0", b.pc_out, b.halted);
    end
    b.resume = 0;
    step();
    checks++;
    if (b.pc_out !== 32'h24) begin
      errors++;
      $display("FAIL resume_next got %h want 24", b.pc_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    b.stall = 1; b.call = 1; b.jump_target = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (b.pc_out !== 32'h100 || b.ras_empty !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d got pc %h e %b want 100 1", i, b.pc_out, b.ras_empty);
      end
    end
    clear_inputs();
    step();
    checks++;
    if (b.pc_out !== 32'h104 || b.ras_empty !== 1'b1) begin
      errors++;
      $display("FAIL stall_end got pc %h e %b want 104 1", b.pc_out, b.ras_empty);
    end
  endtask

  task automatic test_wrap_async();
    logic [7:0] wexp [4];
    wexp[0] = 8'hF8; wexp[1] = 8'hFC;
    wexp[2] = 8'h00; wexp[3] = 8'h04;
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (b8.pc_out !== wexp[i]) begin
        errors++;
        $display("FAIL wrap%0d got %h want %h", i, b8.pc_out, wexp[i]);
      end
    end
    b.halt = 1;
    step();
    b.halt = 0;
    #2;
    reset = 1'b1;
    rst8  = 1'b1;
    #1;
    checks++;
    if (b8.pc_out !== 8'hF4) begin
      errors++;
      $display("FAIL async8 got %h want f4", b8.pc_out);
    end
    checks++;
    if (b.pc_out !== 32'h100 || b.halted !== 1'b0) begin
      errors++;
      $display("FAIL async got pc %h h %b want 100 0", b.pc_out, b.halted);
    end
    @(negedge clk);
    reset = 1'b0;
    rst8  = 1'b0;
    step();
    checks++;
    if (b.pc_out !== 32'h104 || b8.pc_out !== 8'hF8) begin
      errors++;
      $display("FAIL post_rst got %h %h want 104 f8", b.pc_out, b8.pc_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_seq();
    test_branch_jump();
    test_call_chain();
    test_call_ret();
    test_halt();
    test_stall();
    test_wrap_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
